branch_predict_resolve: RTL

- Parametrised successor to the EX-stage branch comparator.
- Resolves conditional branches in EX using the same BranchTypeE encodings from Parameters.v.
- Adds an IF-stage prediction path: a direct-mapped BTB with per-entry saturating counters, trained at resolve time.
- Generates mispredict/redirect for the hazard unit and keeps branch/miss statistics counters.

---
 rtl/branch_predict_resolve.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/branch_predict_resolve.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_resolve
// Purpose  : EX-stage conditional branch resolution combined with an IF-stage
//            direct-mapped BTB predictor (per-entry saturating counters) that
//            is trained when a branch resolves. Produces mispredict/redirect
//            for the hazard unit and saturating branch/miss statistics.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            PCF -> PredTakenF/PredTargetF         - IF lookup (combinational)
//            BranchTypeE, Operand1/2, PCE, BrTargetE,
//            PredTakenE, PredTargetE, StallE, FlushE - EX resolve inputs
//            BranchE, MispredictE, RedirectPCE     - EX resolve outputs
//            BrCount, MissCount                    - statistics
// Revision : 1.0 - initial release
// ============================================================================
module branch_predict_resolve #(
    parameter int XLEN      = 32,
    parameter int ENTRIES   = 64,
    parameter int CTR_BITS  = 2,
    parameter int STAT_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [XLEN-1:0]      PCF,
    output logic                 PredTakenF,
    output logic [XLEN-1:0]      PredTargetF,
    input  logic [2:0]           BranchTypeE,
    input  logic [XLEN-1:0]      Operand1,
    input  logic [XLEN-1:0]      Operand2,
    input  logic [XLEN-1:0]      PCE,
    input  logic [XLEN-1:0]      BrTargetE,
    input  logic                 PredTakenE,
    input  logic [XLEN-1:0]      PredTargetE,
    input  logic                 StallE,
    input  logic                 FlushE,
    output logic                 BranchE,
    output logic                 MispredictE,
    output logic [XLEN-1:0]      RedirectPCE,
    output logic [STAT_BITS-1:0] BrCount,
    output logic [STAT_BITS-1:0] MissCount
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    // Branch type encodings shared with the rest of the pipeline
    localparam logic [2:0] c_NOBRANCH = 3'd0;
    localparam logic [2:0] c_BEQ      = 3'd1;
    localparam logic [2:0] c_BNE      = 3'd2;
    localparam logic [2:0] c_BLT      = 3'd3;
    localparam logic [2:0] c_BLTU     = 3'd4;
    localparam logic [2:0] c_BGE      = 3'd5;
    localparam logic [2:0] c_BGEU     = 3'd6;

    // Weakly taken = MSB set, rest clear; weakly not-taken is one below it
    localparam logic [CTR_BITS-1:0] c_CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] c_CTR_WNT = c_CTR_WT - CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0] c_CTR_MAX = '1;
    localparam logic [STAT_BITS-1:0] c_STAT_MAX = '1;

    // ---------------- Table storage ----------------
    logic                valid_q  [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

    logic [STAT_BITS-1:0] br_count_q, br_count_d;
    logic [STAT_BITS-1:0] miss_count_q, miss_count_d;

    // PC word-alignment bits carry no index/tag information
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

    // ---------------- IF lookup ----------------
    logic [IDX_W-1:0] idx_f;
    logic             hit_f;

    assign idx_f       = PCF[IDX_W+1:2];
    assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == PCF[XLEN-1:IDX_W+2]);
    assign PredTakenF  = hit_f && ctr_q[idx_f][CTR_BITS-1];
    assign PredTargetF = PredTakenF ? target_q[idx_f] : PCF + XLEN'(4);

    // ---------------- EX resolve ----------------
    logic is_branch;
    logic upd;

    always_comb begin
        is_branch = 1'b1;
        BranchE   = 1'b0;
        case (BranchTypeE)
            c_BEQ:   BranchE = (Operand1 == Operand2);
            c_BNE:   BranchE = (Operand1 != Operand2);
            c_BLT:   BranchE = ($signed(Operand1) <  $signed(Operand2));
            c_BLTU:  BranchE = (Operand1 <  Operand2);
            c_BGE:   BranchE = ($signed(Operand1) >= $signed(Operand2));
            c_BGEU:  BranchE = (Operand1 >= Operand2);
            default: is_branch = 1'b0;   // c_NOBRANCH and unused codes
        endcase
    end

    assign upd         = !StallE && !FlushE;
    assign RedirectPCE = BranchE ? BrTargetE : PCE + XLEN'(4);

    // A wrong target only matters when both prediction and outcome are taken
    always_comb begin
        MispredictE = 1'b0;
        if (upd) begin
            if (is_branch)
                MispredictE = (PredTakenE != BranchE) ||
                              (BranchE && PredTakenE && (PredTargetE != BrTargetE));
            else
                MispredictE = PredTakenE;
        end
    end

    // ---------------- Training ----------------
    logic [IDX_W-1:0]    idx_e;
    logic [TAG_W-1:0]    tag_e;
    logic                hit_e;
    logic                tbl_we;
    logic                valid_d;
    logic [TAG_W-1:0]    tag_d;
    logic [XLEN-1:0]     target_d;
    logic [CTR_BITS-1:0] ctr_d;

    assign idx_e = PCE[IDX_W+1:2];
    assign tag_e = PCE[XLEN-1:IDX_W+2];
    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

    always_comb begin
        tbl_we   = 1'b0;
        valid_d  = valid_q[idx_e];
        tag_d    = tag_q[idx_e];
        target_d = target_q[idx_e];
        ctr_d    = ctr_q[idx_e];
        if (upd) begin
            if (is_branch) begin
                if (hit_e) begin
                    tbl_we = 1'b1;
                    if (BranchE) begin
                        target_d = BrTargetE;
                        if (ctr_q[idx_e] != c_CTR_MAX)
                            ctr_d = ctr_q[idx_e] + CTR_BITS'(1);
                    end else if (ctr_q[idx_e] != '0) begin
                        ctr_d = ctr_q[idx_e] - CTR_BITS'(1);
                    end
                end else if (BranchE) begin
                    tbl_we   = 1'b1;
                    valid_d  = 1'b1;
                    tag_d    = tag_e;
                    target_d = BrTargetE;
                    ctr_d    = c_CTR_WT;
                end
            end else if (PredTakenE && hit_e) begin
                // A non-branch was predicted taken: drop the aliasing entry
                tbl_we  = 1'b1;
                valid_d = 1'b0;
            end
        end
    end

    generate
        for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q[g]  <= 1'b0;
                    tag_q[g]    <= '0;
                    target_q[g] <= '0;
                    ctr_q[g]    <= c_CTR_WNT;
                end else if (tbl_we && (idx_e == IDX_W'(g))) begin
                    valid_q[g]  <= valid_d;
                    tag_q[g]    <= tag_d;
                    target_q[g] <= target_d;
                    ctr_q[g]    <= ctr_d;
                end
            end
        end
    endgenerate

    // ---------------- Statistics (saturating) ----------------
    always_comb begin
        br_count_d   = br_count_q;
        miss_count_d = miss_count_q;
        if (upd && is_branch && (br_count_q != c_STAT_MAX))
            br_count_d = br_count_q + STAT_BITS'(1);
        if (MispredictE && (miss_count_q != c_STAT_MAX))
            miss_count_d = miss_count_q + STAT_BITS'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_q   <= '0;
            miss_count_q <= '0;
        end else begin
            br_count_q   <= br_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign BrCount   = br_count_q;
    assign MissCount = miss_count_q;

endmodule
`default_nettype wire
